// File: rtl/spi_peripheral_if.sv
// spi_peripheral_if: host-side byte handshake of the SPI target endpoint.
interface spi_peripheral_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;
    modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid, tx_underrun, busy);
    modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid, tx_underrun, busy);
endinterface

// File: rtl/spi_peripheral.sv
// spi_peripheral: oversampled SPI target, LSB-first bytes, all four cpol/cpha modes.
module spi_peripheral #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    input  logic cpol,
    input  logic cpha,
    output logic miso,
    output logic miso_oe,
    spi_peripheral_if.slave host
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
    logic sclk_s, cs_s, mosi_s, sclk_d, cs_d, cpol_l, cpha_l, hold_full;
    logic cs_fall, cs_rise, lead, trail, load, shift, sample, wr;
    logic [7:0] hold, tx_sr, rx_sr;
    logic [2:0] n;

    assign sclk_s  = sclk_q[SYNC_STAGES-1];
    assign cs_s    = cs_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_q[SYNC_STAGES-1];
    assign cs_fall = cs_d & ~cs_s;
    assign cs_rise = ~cs_d & cs_s;
    assign lead    = (sclk_s ^ sclk_d) & (sclk_s ^ cpol_l);
    assign trail   = (sclk_s ^ sclk_d) & ~(sclk_s ^ cpol_l);
    assign wr      = host.tx_valid & ~hold_full;

    assign miso          = (state_q == ACTIVE) & tx_sr[0];
    assign miso_oe       = state_q == ACTIVE;
    assign host.busy     = state_q == ACTIVE;
    assign host.tx_ready = ~hold_full;

    // On the select edge the mode is not latched yet, so the raw cpha decides the first load.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        sample  = 1'b0;
        if (state_q == IDLE) begin
            state_d = cs_fall ? ACTIVE : IDLE;
            load    = cs_fall & ~cpha;
        end else if (cs_rise) begin
            state_d = IDLE;
        end else begin
            sample = cpha_l ? trail : lead;
            load   = (cpha_l ? lead : trail) & (n == 3'd0);
            shift  = (cpha_l ? lead : trail) & (n != 3'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            sclk_q           <= '0;
            cs_q             <= '1;
            mosi_q           <= '0;
            sclk_d           <= 1'b0;
            cs_d             <= 1'b1;
            cpol_l           <= 1'b0;
            cpha_l           <= 1'b0;
            hold_full        <= 1'b0;
            hold             <= 8'h00;
            tx_sr            <= 8'h00;
            rx_sr            <= 8'h00;
            n                <= 3'd0;
            host.rx_data     <= 8'h00;
            host.rx_valid    <= 1'b0;
            host.tx_underrun <= 1'b0;
        end else begin
            sclk_q           <= {sclk_q[SYNC_STAGES-2:0], sclk};
            cs_q             <= {cs_q[SYNC_STAGES-2:0], cs_n};
            mosi_q           <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_d           <= sclk_s;
            cs_d             <= cs_s;
            state_q          <= state_d;
            host.rx_valid    <= 1'b0;
            host.tx_underrun <= 1'b0;
            if (state_q == IDLE && cs_fall) {cpol_l, cpha_l} <= {cpol, cpha};
            n <= (state_q == IDLE || cs_rise) ? 3'd0 : n + {2'd0, sample};
            if (sample) begin
                rx_sr <= {mosi_s, rx_sr[7:1]};
                if (n == 3'd7) begin
                    host.rx_data  <= {mosi_s, rx_sr[7:1]};
                    host.rx_valid <= 1'b1;
                end
            end
            if (load) begin
                tx_sr            <= hold_full ? hold : 8'h00;
                host.tx_underrun <= ~hold_full;
            end else if (shift) begin
                tx_sr <= {1'b0, tx_sr[7:1]};
            end
            if (wr) hold <= host.tx_data;
            hold_full <= wr | (hold_full & ~load);
        end
    end
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed and random SPI frames against a byte-level controller model.
module tb_spi_peripheral;
    localparam int H = 8;
    logic clk = 1'b0, rst = 1'b1;
    logic sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, cpol = 1'b0, cpha = 1'b0;
    logic miso, miso_oe;
    int checks = 0, errors = 0, urun = 0;
    logic [7:0] rx_log[$];
    logic [7:0] mo[3], gb[3], txb[3];

    spi_peripheral_if bus ();

    spi_peripheral #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .cpol(cpol), .cpha(cpha), .miso(miso), .miso_oe(miso_oe), .host(bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_valid) rx_log.push_back(bus.rx_data);
        if (bus.tx_underrun) urun++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "simulation timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        int t = 0;
        while (bus.tx_ready !== 1'b1 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("tx_ready_wait", {31'd0, bus.tx_ready}, 32'd1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    // Controller side: drives mo[] LSB-first and collects miso into gb[]; cut>0 stops byte 0 early with cs_n still low.
    task automatic run_frame(input logic pol, input logic pha, input int nb, input int cut);
        cpol = pol;
        cpha = pha;
        sclk = pol;
        repeat (6) @(negedge clk);
        cs_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 8; i++) begin
                if (cut > 0 && b == 0 && i == cut) return;
                if (!pha) begin
                    mosi = mo[b][i];
                    repeat (H) @(negedge clk);
                    sclk = ~pol;
                    gb[b][i] = miso;
                    repeat (H) @(negedge clk);
                    sclk = pol;
                end else begin
                    sclk = ~pol;
                    mosi = mo[b][i];
                    repeat (H) @(negedge clk);
                    sclk = pol;
                    gb[b][i] = miso;
                    repeat (H) @(negedge clk);
                end
            end
        end
        repeat (H) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int base, u0, nb;
        logic [1:0] mm;
        logic p, q;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_miso", {31'd0, miso}, 0);
        chk("rst_miso_oe", {31'd0, miso_oe}, 0);
        chk("rst_tx_ready", {31'd0, bus.tx_ready}, 1);
        chk("rst_rx_data", {24'd0, bus.rx_data}, 0);
        chk("rst_rx_valid", {31'd0, bus.rx_valid}, 0);
        chk("rst_underrun", {31'd0, bus.tx_underrun}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);

        wr(8'hA5);
        mo[0] = 8'h3C;
        base = rx_log.size();
        run_frame(1'b0, 1'b0, 1, 0);
        chk("m0_rx_count", rx_log.size() - base, 1);
        chk("m0_rx_data", {24'd0, rx_log[base]}, 32'h3C);
        chk("m0_miso_byte", {24'd0, gb[0]}, 32'hA5);

        for (int m = 1; m < 4; m++) begin
            mm = m[1:0];
            wr(8'h7E);
            mo[0] = 8'h81;
            base = rx_log.size();
            run_frame(mm[1], mm[0], 1, 0);
            chk($sformatf("m%0d_rx_count", m), rx_log.size() - base, 1);
            chk($sformatf("m%0d_rx_data", m), {24'd0, rx_log[base]}, 32'h81);
            chk($sformatf("m%0d_miso_byte", m), {24'd0, gb[0]}, 32'h7E);
        end

        wr(8'h11);
        mo[0] = 8'hF0;
        mo[1] = 8'h0F;
        base = rx_log.size();
        u0 = urun;
        fork
            run_frame(1'b0, 1'b1, 2, 0);
            wr(8'h22);
        join
        chk("b2b_rx_count", rx_log.size() - base, 2);
        chk("b2b_rx0", {24'd0, rx_log[base]}, 32'hF0);
        chk("b2b_rx1", {24'd0, rx_log[base+1]}, 32'h0F);
        chk("b2b_miso0", {24'd0, gb[0]}, 32'h11);
        chk("b2b_miso1", {24'd0, gb[1]}, 32'h22);
        chk("b2b_no_underrun", urun - u0, 0);

        mo[0] = 8'hC3;
        base = rx_log.size();
        u0 = urun;
        run_frame(1'b0, 1'b1, 1, 0);
        chk("urun_miso_byte", {24'd0, gb[0]}, 32'h00);
        chk("urun_pulses", urun - u0, 1);
        chk("urun_rx_data", {24'd0, rx_log[base]}, 32'hC3);

        wr(8'h99);
        mo[0] = 8'hFF;
        base = rx_log.size();
        fork
            run_frame(1'b0, 1'b0, 1, 4);
            wr(8'h55);
        join
        chk("abort_busy_before", {31'd0, bus.busy}, 1);
        chk("abort_oe_before", {31'd0, miso_oe}, 1);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_busy_after", {31'd0, bus.busy}, 0);
        repeat (10) @(negedge clk);
        chk("abort_no_rx", rx_log.size() - base, 0);
        chk("abort_hold_kept", {31'd0, bus.tx_ready}, 0);
        mo[0] = 8'($urandom);
        base = rx_log.size();
        run_frame(1'b0, 1'b0, 1, 0);
        chk("after_abort_miso", {24'd0, gb[0]}, 32'h55);
        chk("after_abort_rx", {24'd0, rx_log[base]}, {24'd0, mo[0]});

        wr(8'h33);
        mo[0] = 8'hB6;
        run_frame(1'b1, 1'b0, 1, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_miso", {31'd0, miso}, 0);
        chk("arst_miso_oe", {31'd0, miso_oe}, 0);
        chk("arst_tx_ready", {31'd0, bus.tx_ready}, 1);
        chk("arst_rx_data", {24'd0, bus.rx_data}, 0);
        chk("arst_rx_valid", {31'd0, bus.rx_valid}, 0);
        chk("arst_underrun", {31'd0, bus.tx_underrun}, 0);
        chk("arst_busy", {31'd0, bus.busy}, 0);
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        wr(8'h6C);
        mo[0] = 8'($urandom);
        base = rx_log.size();
        run_frame(1'b0, 1'b0, 1, 0);
        chk("post_rst_rx_count", rx_log.size() - base, 1);
        chk("post_rst_rx", {24'd0, rx_log[base]}, {24'd0, mo[0]});
        chk("post_rst_miso", {24'd0, gb[0]}, 32'h6C);

        for (int r = 0; r < 6; r++) begin
            p  = 1'($urandom_range(0, 1));
            q  = 1'($urandom_range(0, 1));
            nb = int'($urandom_range(1, 3));
            for (int b = 0; b < 3; b++) begin
                mo[b]  = 8'($urandom);
                txb[b] = 8'($urandom);
            end
            wr(txb[0]);
            base = rx_log.size();
            fork
                run_frame(p, q, nb, 0);
                begin
                    for (int k = 1; k < nb; k++) wr(txb[k]);
                end
            join
            chk($sformatf("rnd%0d_rx_count", r), rx_log.size() - base, nb);
            for (int b = 0; b < nb; b++) begin
                chk($sformatf("rnd%0d_rx%0d", r, b), {24'd0, rx_log[base+b]}, {24'd0, mo[b]});
                chk($sformatf("rnd%0d_miso%0d", r, b), {24'd0, gb[b]}, {24'd0, txb[b]});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI target (slave) endpoint. It is the far end of the team's SPI controller on the same sclk/cs_n/mosi/miso link.
- Oversamples the external SPI pins in the system clock domain and shifts bytes LSB-first, matching the controller's bit order.
- Presents received bytes as a one-cycle tick and accepts transmit bytes through a one-entry valid/ready holding register.
- Supports all four cpol/cpha modes.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizers on sclk, cs_n and mosi (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sclk  in  1  SPI clock from the controller (asynchronous to clk)
- cs_n  in  1  chip select, active low
- mosi  in  1  serial data from the controller
- miso  out  1  serial data to the controller
- miso_oe  out  1  miso output enable; 1 while selected
- cpol  in  1  clock idle level
- cpha  in  1  clock phase
- tx_data  in  8  next byte to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  holding register is empty
- rx_data  out  8  last complete received byte
- rx_valid  out  1  one-cycle tick: rx_data has been updated
- tx_underrun  out  1  one-cycle tick: a byte was loaded while the holding register was empty
- busy  out  1  frame in progress (cs_n low, synchronized)

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0x00, rx_valid=0, tx_underrun=0, busy=0. State=IDLE, bit count n=0, shift registers cleared, holding register empty.
- Synchronization: sclk, cs_n and mosi each pass through SYNC_STAGES flops. mosi uses the same stage depth as sclk so it stays aligned with its edge.
- Edge detection: compare the synchronized sclk with a one-cycle delayed copy.
  - Leading edge: sclk moves away from cpol.
  - Trailing edge: sclk returns to cpol.
- Clock ratio: the sclk half-period must be at least 4 clk. miso changes SYNC_STAGES+1 clk after the pin edge.
- Mode latch: cpol and cpha are latched when synchronized cs_n falls. Changes to them mid-frame are ignored.
- States: IDLE and ACTIVE.
  - IDLE: miso_oe=0, miso=0, busy=0, sclk edges ignored. A synchronized cs_n fall moves to ACTIVE with n=0. If the latched cpha=0, this cycle is also a load event.
  - ACTIVE: busy=1, miso_oe=1, miso = tx shift register bit 0.
- Load event: the tx shift register takes the holding register, and the holding register becomes empty (tx_ready=1 next cycle).
  - If the holding register is empty, the shift register takes 0x00 and tx_underrun pulses for one cycle.
- cpha=0 transfer:
  - Leading edge: sample; rx shift register becomes {mosi, rx[7:1]}; n increments.
  - Trailing edge: if n==0 (byte just completed), load event; otherwise shift the tx register right by one.
- cpha=1 transfer:
  - Leading edge: if n==0, load event; otherwise shift the tx register right.
  - Trailing edge: sample; n increments.
- Byte complete: on the 8th sample (n goes 7 to 0), rx_data is updated with the full byte in the following cycle, with rx_valid=1 for exactly that cycle.
- Back-to-back bytes: frames stay in ACTIVE while cs_n is low, and n wraps 7 to 0. There is no gap requirement between bytes.
- Holding register write: on tx_valid && tx_ready, store tx_data; tx_ready=0 next cycle.
- Write and load in the same cycle:
  - Holding empty: the load sees empty, so 0x00 is sent and tx_underrun pulses. The write lands in the holding register (no bypass).
  - Holding full: tx_ready=0, so the write is blocked and the load takes the old contents.
- Abort: synchronized cs_n rising in ACTIVE returns to IDLE the next cycle.
  - The partial byte is discarded, no rx_valid is produced, and n=0.
  - An unconsumed holding register is retained.
- cs_n falling when sclk is not at its idle level is an illegal controller behaviour and is not checked.
- rx has no backpressure. The consumer must take rx_data within 8 sclk periods, before it is overwritten.
- Asynchronous rst at any time, including mid-frame, forces the reset values immediately.

Test Plan:
- Mode 0 (cpol=0, cpha=0), holding=0xA5 before cs_n fall, controller sends 0x3C at a half-period of 8 clk → rx_data=0x3C with a single rx_valid tick; controller receives 0xA5; miso bits LSB-first 1,0,1,0,0,1,0,1.
- Modes 1, 2 and 3 repeat the exchange, with controller mosi 0x81 and holding 0x7E → rx_data=0x81, controller receives 0x7E in every mode.
- Two-byte frame with holding 0x11, then 0x22 written when tx_ready rises, controller sends 0xF0 then 0x0F → rx_valid ticks twice (0xF0, 0x0F); controller receives 0x11, 0x22; tx_underrun never pulses.
- Holding empty at cs_n fall → miso sends 0x00; one tx_underrun pulse; rx still captures the controller byte.
- cs_n deasserts after 4 bits with holding 0x55 pending → no rx_valid, busy=0 within SYNC_STAGES+1 clk; the next frame delivers 0x55 and a complete byte.
- rst asserted mid-byte (after bit 3) → all outputs at reset values in the same cycle; a subsequent frame transfers correctly with n starting at 0.
